// File: rtl/seq_detect_1011.sv
// seq_detect_1011: overlapping serial detector for the bit pattern 1011.
// Data is sampled once per rising edge of clk_div (used only as a strobe,
// never as a clock). The detect output is a registered one-clk pulse.
// Optional feature: define DETECT_CNT_EN to add the saturating det_cnt
// counter and its output port.
//
// Handshake/strobe semantics: there is no valid/ready pair here. A "tick"
// is the single clk cycle in which en=1, clk_div=1 and the registered copy
// of clk_div is 0; din is consumed only in that cycle and ignored otherwise.
module seq_detect_1011 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_div,
    input  logic             din,
    input  logic             en,
    input  logic             clr,
    output logic             detect,
    output logic [1:0]       state_o
`ifdef DETECT_CNT_EN
    ,
    output logic [CNT_W-1:0] det_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S1   = 2'd1,
        S10  = 2'd2,
        S101 = 2'd3
    } state_t;

    state_t state;
    logic   clk_div_q;
    logic   tick;

    // A counter narrower than one bit is meaningless; this block only
    // exists to make an illegal CNT_W visible during elaboration.
    if (CNT_W < 1) begin : g_cnt_w_invalid
    end

    // Edge-detect history for clk_div. Resets high so a clk_div that is
    // already high when reset releases is not mistaken for a rising edge.
    // clr deliberately leaves this register alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_div_q <= 1'b1;
        end else begin
            clk_div_q <= clk_div;
        end
    end

    // One-cycle sample strobe per clk_div rising edge, gated by en.
    assign tick = en & clk_div & ~clk_div_q;

    // Pattern FSM with registered detect pulse (and optional counter).
    // clr wins over a simultaneous tick, discarding that tick's bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            detect  <= 1'b0;
`ifdef DETECT_CNT_EN
            det_cnt <= '0;
`endif
        end else if (clr) begin
            state   <= IDLE;
            detect  <= 1'b0;
`ifdef DETECT_CNT_EN
            det_cnt <= '0;
`endif
        end else begin
            detect <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE:    state <= din ? S1 : IDLE;
                    S1:      state <= din ? S1 : S10;
                    S10:     state <= din ? S101 : IDLE;
                    S101: begin
                        // Overlap: the trailing 1 of a match is the
                        // leading 1 of the next candidate, hence S1.
                        state  <= din ? S1 : S10;
                        detect <= din;
`ifdef DETECT_CNT_EN
                        if (din && (det_cnt != {CNT_W{1'b1}})) begin
                            det_cnt <= det_cnt + 1'b1;
                        end
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_seq_detect_1011.sv
// Directed bench for seq_detect_1011. clk_div is generated as clk/4
// (two cycles high, two low). Expected {detect, state} per tick are
// hand-computed and queued in exp_q; detect pulse widths are tracked by
// counting high clk cycles at the falling edge.
module tb_seq_detect_1011;

    localparam int CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic             clk_div;
    logic             din;
    logic             en;
    logic             clr;
    logic             detect;
    logic [1:0]       state_o;
`ifdef DETECT_CNT_EN
    logic [CNT_W-1:0] det_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int pulse_cycles = 0;
    int pulse_base = 0;

    logic       last_det;
    logic       det_after;
    logic [1:0] last_st;
    logic [2:0] exp_q[$];   // {detect, state} expected right after each tick

    seq_detect_1011 #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_div (clk_div),
        .din     (din),
        .en      (en),
        .clr     (clr),
        .detect  (detect),
        .state_o (state_o)
`ifdef DETECT_CNT_EN
        ,
        .det_cnt (det_cnt)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // count every clk cycle in which detect is high
    always @(negedge clk) begin
        if (detect === 1'b1) pulse_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clk_div period (2 high, 2 low). The tick is the first high cycle.
    task automatic div_period(input logic d, input logic c);
        @(posedge clk); #1;
        clk_div = 1'b1; din = d; clr = c;
        @(posedge clk); #1;
        last_det = detect;
        last_st  = state_o;
        clr = 1'b0;
        din = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        det_after = detect;
        clk_div = 1'b0;
        din = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
    endtask

    task automatic run_bits(input string tag, input logic [15:0] bits, input int n);
        logic [2:0] e;
        for (int i = n - 1; i >= 0; i--) begin
            div_period(bits[i], 1'b0);
            e = exp_q.pop_front();
            check($sformatf("%s_tick%0d", tag, n - i), {29'd0, last_det, last_st}, {29'd0, e});
            check($sformatf("%s_after%0d", tag, n - i), {31'd0, det_after}, 32'd0);
        end
    endtask

    task automatic do_clr();
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        pulse_base = pulse_cycles;
    endtask

    initial begin
        rst_n = 1'b0; clk_div = 1'b0; din = 1'b0; en = 1'b1; clr = 1'b0;
        #1;
        check("reset_state", {30'd0, state_o}, 32'd0);
        check("reset_detect", {31'd0, detect}, 32'd0);
`ifdef DETECT_CNT_EN
        check("reset_cnt", {30'd0, det_cnt}, 32'd0);
`endif
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        pulse_base = pulse_cycles;

        // basic 1011: states 1,2,3,1 with detect on the 4th tick
        exp_q = '{3'b001, 3'b010, 3'b011, 3'b101};
        run_bits("basic", 16'b1011, 4);
        check("basic_pulses", pulse_cycles - pulse_base, 32'd1);
`ifdef DETECT_CNT_EN
        check("basic_cnt", {30'd0, det_cnt}, 32'd1);
`endif

        // overlapping 1011011 -> two matches
        do_clr();
        exp_q = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b010, 3'b011, 3'b101};
        run_bits("overlap", 16'b1011011, 7);
        check("overlap_pulses", pulse_cycles - pulse_base, 32'd2);
`ifdef DETECT_CNT_EN
        check("overlap_cnt", {30'd0, det_cnt}, 32'd2);
`endif

        // 11001011 -> falls back to IDLE on the 4th tick, one match at the 8th
        do_clr();
        exp_q = '{3'b001, 3'b001, 3'b010, 3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
        run_bits("fallback", 16'b11001011, 8);
        check("fallback_pulses", pulse_cycles - pulse_base, 32'd1);

        // en low mid-pattern: partial match held, resumed afterwards
        do_clr();
        exp_q = '{3'b001, 3'b010, 3'b011};
        run_bits("en_pre", 16'b101, 3);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            div_period(1'($urandom_range(0, 1)), 1'b0);
            check($sformatf("en_hold_state%0d", k), {30'd0, last_st}, 32'd3);
            check($sformatf("en_hold_det%0d", k), {31'd0, last_det}, 32'd0);
        end
        en = 1'b1;
        exp_q = '{3'b101};
        run_bits("en_resume", 16'b1, 1);
        check("en_pulses", pulse_cycles - pulse_base, 32'd1);

        // clr in the same cycle as the completing tick
        do_clr();
        exp_q = '{3'b001, 3'b010, 3'b011};
        run_bits("clr_pre", 16'b101, 3);
        div_period(1'b1, 1'b1);
        check("clr_state", {30'd0, last_st}, 32'd0);
        check("clr_det", {31'd0, last_det}, 32'd0);
        check("clr_pulses", pulse_cycles - pulse_base, 32'd0);
`ifdef DETECT_CNT_EN
        check("clr_cnt", {30'd0, det_cnt}, 32'd0);
`endif

        // reset mid-pattern, released while clk_div is high
        exp_q = '{3'b001, 3'b010, 3'b011};
        run_bits("rst_pre", 16'b101, 3);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rst_async_state", {30'd0, state_o}, 32'd0);
        clk_div = 1'b1; din = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulse_base = pulse_cycles;
        @(posedge clk); #1;
        check("rst_no_tick0", {30'd0, state_o}, 32'd0);
        @(posedge clk); #1;
        check("rst_no_tick1", {30'd0, state_o}, 32'd0);
        clk_div = 1'b0;
        @(posedge clk); #1;
        exp_q = '{3'b001};
        run_bits("rst_post", 16'b1, 1);
        check("rst_pulses", pulse_cycles - pulse_base, 32'd0);

        // five overlapping matches: counter saturates at 3 for CNT_W=2
        do_clr();
        exp_q = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b010, 3'b011, 3'b101,
                  3'b010, 3'b011, 3'b101, 3'b010, 3'b011, 3'b101,
                  3'b010, 3'b011, 3'b101};
        run_bits("sat", 16'b1011011011011011, 16);
        check("sat_pulses", pulse_cycles - pulse_base, 32'd5);
`ifdef DETECT_CNT_EN
        check("sat_cnt", {30'd0, det_cnt}, 32'd3);
        repeat (4) @(posedge clk);
        #1;
        check("sat_cnt_hold", {30'd0, det_cnt}, 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
